router_sync: RTL
================

# router_sync

Synchronizer between the router input controller FSM and the three output FIFOs of the 1x3 router. It does three things:
- Latches the 2-bit destination address from each packet header.
- Steers the FSM's single write request to the matching FIFO as a one-hot write enable, and reports that FIFO's full flag back to the FSM.
- Drives a valid flag per output port and generates a per-FIFO soft reset when a destination leaves data unread for too long.

## Interface
Parameters:
- TIMEOUT, 30: number of consecutive valid-but-unread cycles before that FIFO's soft reset fires.
- CNT_W, 5: timeout counter width; must satisfy TIMEOUT <= 2**CNT_W.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- detect_add  in  1  from FSM; high for one cycle while the header byte is on the input bus.
- data_in  in  2  header address bits [1:0]; 0/1/2 select FIFO 0/1/2, 3 is invalid.
- write_enb_reg  in  1  from FSM; request to write the current byte.
- read_enb_0, read_enb_1, read_enb_2  in  1 each  per-port read strobe from the destination.
- empty_0, empty_1, empty_2  in  1 each  FIFO empty flags.
- full_0, full_1, full_2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enables; bit n drives FIFO n wr_en.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out_0, vld_out_1, vld_out_2  out  1 each  port has data available.
- soft_reset_0, soft_reset_1, soft_reset_2  out  1 each  one-cycle soft reset to FIFO n.

## Operation
Address register addr_reg (2 bits):
- Reset value: 2'b11 (invalid).
- On any edge with detect_add = 1: addr_reg <= data_in.
- Otherwise it holds its value.

write_enb (combinational):
- write_enb_reg = 0: 3'b000.
- write_enb_reg = 1 with addr_reg = 0/1/2: 3'b001 / 3'b010 / 3'b100.
- write_enb_reg = 1 with addr_reg = 3: 3'b000. The packet is dropped; no FIFO is written.

fifo_full (combinational):
- addr_reg = n: full_n.
- addr_reg = 3: 0, so the FSM never stalls on an invalid address.

vld_out_n (combinational): ~empty_n.

Timeout logic, one instance per port n, each with its own counter cnt_n (CNT_W bits). At each edge:
- If vld_out_n = 0 or read_enb_n = 1: cnt_n <= 0, soft_reset_n <= 0.
- Else if cnt_n == TIMEOUT-1: cnt_n <= 0, soft_reset_n <= 1.
- Else: cnt_n <= cnt_n + 1, soft_reset_n <= 0.

Counter arithmetic: unsigned; never wraps, because it clears at TIMEOUT-1.

Reset values: addr_reg = 3, all cnt_n = 0, all soft_reset_n = 0. With all empty_n = 1 and write_enb_reg = 0, the outputs are write_enb = 0, fifo_full = 0 and vld_out_n = 0.

## Timing
- Address latency: addr_reg changes on the edge where detect_add = 1. A write_enb_reg asserted in the same cycle as detect_add uses the OLD address; the FSM never asserts both together.
- write_enb, fifo_full and vld_out_n are combinational from registered or input state, with zero cycles of latency.
- Soft reset timing:
  - soft_reset_n rises on the edge that ends the TIMEOUT-th consecutive cycle in which vld_out_n = 1 and read_enb_n = 0.
  - It is high for exactly one cycle.
  - The FIFO clears on the following edge.
- If read_enb_n is asserted in the same cycle that cnt_n == TIMEOUT-1, the read wins: cnt_n goes to 0 and no soft reset is generated.
- If vld_out_n is still 1 during the soft_reset_n cycle (the FIFO has not yet cleared), counting restarts from 0. No second pulse occurs, because the FIFO empties before a second pulse could be due.
- Ports are independent: simultaneous timeouts on several ports each produce their own pulse in the same cycle.
- rst asserted mid-operation: all registers return to their reset values immediately (asynchronously), including a soft_reset_n that is currently high. rst is released synchronously with respect to clk by the top-level reset synchronizer.

## Test plan
- Reset: hold rst = 0 with empty_n = 1 and full_n = 0 -> write_enb = 000, fifo_full = 0, all vld_out_n = 0, all soft_reset_n = 0. Drive write_enb_reg = 1 -> write_enb stays 000 (addr_reg = 3).
- Address steering: detect_add = 1 with data_in = 2 for one cycle, then write_enb_reg = 1 -> write_enb = 100. Repeat with data_in = 0 -> write_enb = 001. Repeat with data_in = 3 -> write_enb = 000.
- Full mux: addr_reg = 1, full_1 = 1, full_0 = 0 -> fifo_full = 1. Set addr_reg = 0 -> fifo_full = 0.
- Timeout: empty_0 = 0 and read_enb_0 = 0 held -> soft_reset_0 rises exactly 30 edges later and drops after 1 cycle. soft_reset_1 and soft_reset_2 stay 0.
- Timeout rescue: empty_1 = 0, pulse read_enb_1 = 1 on cycle 29 -> no soft_reset_1. A new count begins, and soft_reset_1 fires 30 cycles after read_enb_1 drops.
- Reset mid-count: empty_2 = 0 for 20 cycles, pulse rst low, release -> cnt_2 restarts. soft_reset_2 fires 30 cycles after release, not 10.

Source files
------------

// File: rtl/router_sync.sv
// Glue between the router input FSM and its three output FIFOs: header address latch,
// write steering, full-flag mux, per-port valid flags and per-port read-timeout soft resets.
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    logic [1:0] addr_reg;
    logic [2:0] vld;
    logic [2:0] rd;
    logic [2:0] soft_reset_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg <= 2'b11;
        end else if (detect_add) begin
            addr_reg <= data_in;
        end
    end

    // Address 3 is invalid: the packet is dropped and the FSM is never stalled.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_reg)
            2'd0: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'd1: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'd2: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld = {~empty_2, ~empty_1, ~empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_timeout
            logic [CNT_W-1:0] cnt_reg;

            // A read in the final cycle wins over the timeout.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg           <= '0;
                    soft_reset_reg[gi] <= 1'b0;
                end else if (!vld[gi] || rd[gi]) begin
                    cnt_reg           <= '0;
                    soft_reset_reg[gi] <= 1'b0;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    cnt_reg           <= '0;
                    soft_reset_reg[gi] <= 1'b1;
                end else begin
                    cnt_reg           <= cnt_reg + CNT_W'(1);
                    soft_reset_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign soft_reset_0 = soft_reset_reg[0];
    assign soft_reset_1 = soft_reset_reg[1];
    assign soft_reset_2 = soft_reset_reg[2];

endmodule
